// File: rtl/idct4_pipe.sv
// idct4_pipe: 3-stage pipelined 4-point HEVC inverse DCT (64/83/36 kernel) with a per-vector rounding shift.
// Define IDCT4_CLIP_EN to saturate each output lane and report it on sat_flag; otherwise lanes wrap to OUT_W bits.
module idct4_pipe #(
  parameter int IN_W   = 16,
  parameter int OUT_W  = 16,
  parameter int SHIFT1 = 7,
  parameter int SHIFT2 = 12
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    stage_sel,
  input  logic signed [IN_W-1:0]  x0,
  input  logic signed [IN_W-1:0]  x1,
  input  logic signed [IN_W-1:0]  x2,
  input  logic signed [IN_W-1:0]  x3,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] y0,
  output logic signed [OUT_W-1:0] y1,
  output logic signed [OUT_W-1:0] y2,
  output logic signed [OUT_W-1:0] y3,
  output logic                    sat_flag
);
  localparam int ACC_W = IN_W + 10;
  localparam logic signed [ACC_W-1:0] C83  = ACC_W'(83);
  localparam logic signed [ACC_W-1:0] C36  = ACC_W'(36);
  localparam logic signed [ACC_W-1:0] RND1 = ACC_W'(1) << (SHIFT1 - 1);
  localparam logic signed [ACC_W-1:0] RND2 = ACC_W'(1) << (SHIFT2 - 1);
`ifdef IDCT4_CLIP_EN
  localparam logic signed [ACC_W-1:0] OMAX = ACC_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] OMIN = ~OMAX;
`endif

  logic                    en;
  logic signed [IN_W-1:0]  x_in [4];
  logic signed [ACC_W-1:0] xs [4];
  logic signed [ACC_W-1:0] e0_next, e1_next, o0_next, o1_next;
  logic signed [ACC_W-1:0] e0_reg, e1_reg, o0_reg, o1_reg;
  logic                    valid1_reg, sel1_reg, valid2_reg, sel2_reg;
  logic signed [ACC_W-1:0] sum_next [4];
  logic signed [ACC_W-1:0] sum_reg [4];
  logic signed [OUT_W-1:0] lane_next [4];
  logic [3:0]              clip_lane;
  logic signed [OUT_W-1:0] y_reg [4];
  logic                    out_valid_reg, sat_reg;

  // One global advance: a stalled output freezes every stage, bubbles included.
  assign en       = !out_valid_reg || out_ready;
  assign in_ready = en;

  assign x_in[0] = x0;
  assign x_in[1] = x1;
  assign x_in[2] = x2;
  assign x_in[3] = x3;

  for (genvar gi = 0; gi < 4; gi++) begin : g_sext
    assign xs[gi] = {{(ACC_W - IN_W){x_in[gi][IN_W-1]}}, x_in[gi]};
  end

  always_comb begin
    e0_next = (xs[0] + xs[2]) <<< 6;
    e1_next = (xs[0] - xs[2]) <<< 6;
    o0_next = C83 * xs[1] + C36 * xs[3];
    o1_next = C36 * xs[1] - C83 * xs[3];
  end

  always_comb begin
    sum_next[0] = e0_reg + o0_reg;
    sum_next[1] = e1_reg + o1_reg;
    sum_next[2] = e1_reg - o1_reg;
    sum_next[3] = e0_reg - o0_reg;
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic signed [ACC_W-1:0] rnd, shf;

    // Round-half-up then arithmetic shift, i.e. floor after the offset add.
    always_comb begin
      rnd = sum_reg[gi] + (sel2_reg ? RND2 : RND1);
      shf = sel2_reg ? (rnd >>> SHIFT2) : (rnd >>> SHIFT1);
    end

`ifdef IDCT4_CLIP_EN
    logic signed [OUT_W-1:0] lane_y;
    logic                    lane_clip;

    always_comb begin
      lane_y    = shf[OUT_W-1:0];
      lane_clip = 1'b0;
      if (shf > OMAX) begin
        lane_y    = OMAX[OUT_W-1:0];
        lane_clip = 1'b1;
      end else if (shf < OMIN) begin
        lane_y    = OMIN[OUT_W-1:0];
        lane_clip = 1'b1;
      end
    end

    assign lane_next[gi] = lane_y;
    assign clip_lane[gi] = lane_clip;
`else
    logic lane_unused;

    assign lane_unused   = ^shf[ACC_W-1:OUT_W];
    assign lane_next[gi] = shf[OUT_W-1:0];
    assign clip_lane[gi] = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid1_reg    <= 1'b0;
      sel1_reg      <= 1'b0;
      e0_reg        <= '0;
      e1_reg        <= '0;
      o0_reg        <= '0;
      o1_reg        <= '0;
      valid2_reg    <= 1'b0;
      sel2_reg      <= 1'b0;
      sum_reg       <= '{default: '0};
      out_valid_reg <= 1'b0;
      y_reg         <= '{default: '0};
      sat_reg       <= 1'b0;
    end else if (en) begin
      valid1_reg    <= in_valid;
      sel1_reg      <= stage_sel;
      e0_reg        <= e0_next;
      e1_reg        <= e1_next;
      o0_reg        <= o0_next;
      o1_reg        <= o1_next;
      valid2_reg    <= valid1_reg;
      sel2_reg      <= sel1_reg;
      sum_reg       <= sum_next;
      out_valid_reg <= valid2_reg;
      y_reg         <= lane_next;
      sat_reg       <= |clip_lane;
    end
  end

  assign out_valid = out_valid_reg;
  assign sat_flag  = sat_reg;
  assign y0        = y_reg[0];
  assign y1        = y_reg[1];
  assign y2        = y_reg[2];
  assign y3        = y_reg[3];

endmodule

// File: tb/tb_idct4_pipe.sv
// Bench for idct4_pipe: directed vectors, stall/back-to-back, alternating shifts, random traffic and reset flush.
// Expected values come from an integer IDCT model and a 3-deep latency model with a global stall.
module tb_idct4_pipe;
  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic               stage_sel;
  logic signed [15:0] x0, x1, x2, x3;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] y0, y1, y2, y3;
  logic               sat_flag;

  int checks   = 0;
  int failures = 0;

  // Latency model: slot 2 is what the output register should show.
  bit          exp_v [3];
  bit          exp_s [3];
  logic [63:0] exp_y [3];

  idct4_pipe #(.IN_W(16), .OUT_W(16), .SHIFT1(7), .SHIFT2(12)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .stage_sel(stage_sel), .x0(x0), .x1(x1), .x2(x2), .x3(x3),
    .out_valid(out_valid), .out_ready(out_ready),
    .y0(y0), .y1(y1), .y2(y2), .y3(y3), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference IDCT from the kernel definition; returns {sat, y3, y2, y1, y0}.
  function automatic logic [64:0] ref_idct(input int a0, input int a1, input int a2, input int a3, input bit sel);
    longint      s [4];
    longint      r;
    int          sh;
    logic [63:0] yv;
    bit          sat;
    sh   = sel ? 12 : 7;
    yv   = '0;
    sat  = 1'b0;
    s[0] = longint'(64 * (a0 + a2) + 83 * a1 + 36 * a3);
    s[1] = longint'(64 * (a0 - a2) + 36 * a1 - 83 * a3);
    s[2] = longint'(64 * (a0 - a2) - 36 * a1 + 83 * a3);
    s[3] = longint'(64 * (a0 + a2) - 83 * a1 - 36 * a3);
    for (int k = 0; k < 4; k++) begin
      r = (s[k] + (longint'(1) <<< (sh - 1))) >>> sh;
`ifdef IDCT4_CLIP_EN
      if (r > 32767) begin
        r   = 32767;
        sat = 1'b1;
      end else if (r < -32768) begin
        r   = -32768;
        sat = 1'b1;
      end
`endif
      yv[k*16 +: 16] = r[15:0];
    end
    return {sat, yv};
  endfunction

  function automatic logic [63:0] pk(input int a, input int b, input int c, input int d);
    return {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  function automatic logic signed [15:0] rnd16();
    case ($urandom_range(0, 7))
      0:       return 16'sh7fff;
      1:       return 16'sh8000;
      default: return 16'($urandom);
    endcase
  endfunction

  function automatic bit model_in_ready();
    return !exp_v[2] || out_ready;
  endfunction

  task automatic clear_model();
    for (int k = 0; k < 3; k++) begin
      exp_v[k] = 1'b0;
      exp_s[k] = 1'b0;
      exp_y[k] = '0;
    end
  endtask

  task automatic set_in(input bit v, input logic signed [15:0] a0, input logic signed [15:0] a1,
                        input logic signed [15:0] a2, input logic signed [15:0] a3,
                        input bit sel, input bit ordy);
    in_valid  = v;
    x0        = a0;
    x1        = a1;
    x2        = a2;
    x3        = a3;
    stage_sel = sel;
    out_ready = ordy;
  endtask

  // Advance one clock and the latency model with it; returns 1 ns after the edge.
  task automatic tick();
    logic [64:0] m;
    @(posedge clk);
    if (!exp_v[2] || out_ready) begin
      m        = ref_idct(x0, x1, x2, x3, stage_sel);
      exp_v[2] = exp_v[1];
      exp_y[2] = exp_y[1];
      exp_s[2] = exp_s[1];
      exp_v[1] = exp_v[0];
      exp_y[1] = exp_y[0];
      exp_s[1] = exp_s[0];
      exp_v[0] = in_valid;
      exp_y[0] = m[63:0];
      exp_s[0] = m[64];
    end
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if (out_valid !== 1'b0 || {y3, y2, y1, y0} !== 64'h0 || sat_flag !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: out_valid=%b y=%h sat=%b, want 0/0/0", out_valid, {y3, y2, y1, y0}, sat_flag);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: in_ready=%b, want 1", in_ready);
    end
  endtask

  task automatic test_directed();
    int          tx [6][4];
    bit          tsel [6];
    logic [63:0] ty [6];
    bit          tsat [6];
    tx[0] = '{64, 0, 0, 0};          tsel[0] = 0; ty[0] = pk(32, 32, 32, 32);     tsat[0] = 0;
    tx[1] = '{0, 1, 0, 0};           tsel[1] = 0; ty[1] = pk(1, 0, 0, -1);        tsat[1] = 0;
    tx[2] = '{0, 1, 0, 0};           tsel[2] = 1; ty[2] = pk(0, 0, 0, 0);         tsat[2] = 0;
    tx[3] = '{-64, 0, 0, 0};         tsel[3] = 0; ty[3] = pk(-32, -32, -32, -32); tsat[3] = 0;
`ifdef IDCT4_CLIP_EN
    tx[4] = '{32767, 32767, 32767, 32767};     tsel[4] = 0; ty[4] = pk(32767, -12032, 12032, 2304);  tsat[4] = 1;
    tx[5] = '{-32768, -32768, -32768, -32768}; tsel[5] = 0; ty[5] = pk(-32768, 12032, -12032, -2304); tsat[5] = 1;
`else
    tx[4] = '{32767, 32767, 32767, 32767};     tsel[4] = 0; ty[4] = pk(-2306, -12032, 12032, 2304);  tsat[4] = 0;
    tx[5] = '{-32768, -32768, -32768, -32768}; tsel[5] = 0; ty[5] = pk(2304, 12032, -12032, -2304);  tsat[5] = 0;
`endif
    for (int i = 0; i < 6; i++) begin
      set_in(1'b1, 16'(tx[i][0]), 16'(tx[i][1]), 16'(tx[i][2]), 16'(tx[i][3]), tsel[i], 1'b1);
      tick();
      set_in(1'b0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 1'b0, 1'b1);
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL directed_latency[%0d]: out_valid=%b two edges after accept, want 0", i, out_valid);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || {y3, y2, y1, y0} !== ty[i] || sat_flag !== tsat[i]) begin
        failures++;
        $display("FAIL directed[%0d]: valid=%b y=(%0d,%0d,%0d,%0d) sat=%b, want 1 y=%h sat=%b",
                 i, out_valid, y0, y1, y2, y3, sat_flag, ty[i], tsat[i]);
      end
    end
    set_in(1'b0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 1'b0, 1'b1);
    tick();
  endtask

  task automatic test_back_to_back();
    logic signed [15:0] v [8][4];
    int                 idx = 0;
    int                 nout = 0;
    int                 c = 0;
    bit                 held = 1'b0;
    logic [64:0]        held_out;
    for (int i = 0; i < 8; i++)
      for (int k = 0; k < 4; k++) v[i][k] = rnd16();
    while (nout < 8 && c < 40) begin
      if (idx < 8)
        set_in(1'b1, v[idx][0], v[idx][1], v[idx][2], v[idx][3], 1'(idx % 2), !(c >= 4 && c <= 6));
      else
        set_in(1'b0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 1'b0, !(c >= 4 && c <= 6));
      #1;
      checks++;
      if (in_ready !== model_in_ready() || in_ready !== !(c >= 4 && c <= 6)) begin
        failures++;
        $display("FAIL b2b_in_ready c=%0d: in_ready=%b, want %b", c, in_ready, !(c >= 4 && c <= 6));
      end
      if (idx < 8 && model_in_ready()) idx++;
      if (exp_v[2] && out_ready) nout++;
      held     = out_valid && !out_ready;
      held_out = {sat_flag, y3, y2, y1, y0};
      tick();
      checks++;
      if (out_valid !== exp_v[2] || (exp_v[2] && ({sat_flag, y3, y2, y1, y0} !== {exp_s[2], exp_y[2]}))) begin
        failures++;
        $display("FAIL b2b_out c=%0d: valid=%b y=%h sat=%b, want valid=%b y=%h sat=%b",
                 c, out_valid, {y3, y2, y1, y0}, sat_flag, exp_v[2], exp_y[2], exp_s[2]);
      end
      if (held) begin
        checks++;
        if ({sat_flag, y3, y2, y1, y0} !== held_out || out_valid !== 1'b1) begin
          failures++;
          $display("FAIL b2b_hold c=%0d: out=%h changed from %h while stalled", c, {sat_flag, y3, y2, y1, y0}, held_out);
        end
      end
      c++;
    end
    checks++;
    if (nout != 8) begin
      failures++;
      $display("FAIL b2b_count: %0d outputs transferred, want 8", nout);
    end
  endtask

  task automatic test_alternating();
    int nsent = 0;
    int nseen = 0;
    logic [63:0] want;
    for (int c = 0; c < 12; c++) begin
      if (nsent < 6) begin
        set_in(1'b1, 16'sd4096, 16'sd0, 16'sd0, 16'sd0, 1'(nsent % 2), 1'b1);
        nsent++;
      end else begin
        set_in(1'b0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 1'b0, 1'b1);
      end
      tick();
      if (out_valid === 1'b1) begin
        want = (nseen % 2 == 0) ? pk(2048, 2048, 2048, 2048) : pk(64, 64, 64, 64);
        checks++;
        if ({y3, y2, y1, y0} !== want) begin
          failures++;
          $display("FAIL alternating[%0d]: y=(%0d,%0d,%0d,%0d), want %h", nseen, y0, y1, y2, y3, want);
        end
        nseen++;
      end
    end
    checks++;
    if (nseen != 6) begin
      failures++;
      $display("FAIL alternating_count: %0d outputs, want 6", nseen);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      set_in($urandom_range(0, 3) != 0, rnd16(), rnd16(), rnd16(), rnd16(),
             1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
      #1;
      checks++;
      if (in_ready !== model_in_ready()) begin
        failures++;
        $display("FAIL random_in_ready c=%0d: in_ready=%b, want %b", c, in_ready, model_in_ready());
      end
      tick();
      checks++;
      if (out_valid !== exp_v[2] || (exp_v[2] && ({sat_flag, y3, y2, y1, y0} !== {exp_s[2], exp_y[2]}))) begin
        failures++;
        $display("FAIL random_out c=%0d: valid=%b y=%h sat=%b, want valid=%b y=%h sat=%b",
                 c, out_valid, {y3, y2, y1, y0}, sat_flag, exp_v[2], exp_y[2], exp_s[2]);
      end
    end
  endtask

  task automatic test_reset_flush();
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, rnd16(), rnd16(), rnd16(), rnd16(), 1'($urandom_range(0, 1)), 1'b1);
      tick();
    end
    set_in(1'b0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 1'b0, 1'b1);
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL flush_pre: out_valid=%b before reset, want 1", out_valid);
    end
    #2;
    reset = 1'b1;
    clear_model();
    #1;
    checks++;
    if (out_valid !== 1'b0 || {y3, y2, y1, y0} !== 64'h0 || sat_flag !== 1'b0) begin
      failures++;
      $display("FAIL flush_immediate: valid=%b y=%h sat=%b, want 0/0/0", out_valid, {y3, y2, y1, y0}, sat_flag);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL flush_idle c=%0d: out_valid=%b after reset release, want 0", c, out_valid);
      end
    end
    set_in(1'b1, rnd16(), rnd16(), rnd16(), rnd16(), 1'b1, 1'b1);
    tick();
    set_in(1'b0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 1'b0, 1'b1);
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b1 || {sat_flag, y3, y2, y1, y0} !== {exp_s[2], exp_y[2]}) begin
      failures++;
      $display("FAIL flush_restart: valid=%b y=%h sat=%b, want 1 y=%h sat=%b",
               out_valid, {y3, y2, y1, y0}, sat_flag, exp_y[2], exp_s[2]);
    end
  endtask

  initial begin
    reset = 1'b1;
    set_in(1'b0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 1'b0, 1'b0);
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_directed();
    test_back_to_back();
    test_alternating();
    test_random();
    test_reset_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
